lcd_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single LCD character/command writer between NUM_REQ requesters, e.g. keyboard echo, status line and song-title writers. It grants one requester at a time and muxes that requester's byte and command flag onto the writer bus. It then sequences the start/finished handshake and returns a per-requester done pulse. A watchdog aborts any transaction whose writer never reports finished.

---
 rtl/lcd_write_arbiter.sv | 127 ++++++++++++
 tb/tb_lcd_write_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD character/command writer among NUM_REQ requesters.
// Latency: req seen in IDLE -> start pulse next cycle; writer finished -> done pulse next cycle.
// Backpressure: requesters hold req level until their done pulse; a watchdog aborts a writer that never finishes.
module lcd_write_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic                   sm_clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_DB,
    input  logic [NUM_REQ-1:0]     req_is_command,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   start_LCD_writer,
    input  logic                   LCD_writer_finished,
    output logic [7:0]             DB,
    output logic                   is_command
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             win_vld;
    logic [7:0]       db_q;
    logic             cmd_q;
    logic [TO_W-1:0]  wdog;
    logic             wdog_lim;
    logic [7:0]       req_db_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_db_arr[i] = req_DB[8*i +: 8];
        end
    end

    // Scan downward so the candidate closest after 'last' is the one left standing.
    always_comb begin
        winner  = last;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                winner  = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign wdog_lim = (wdog == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sm_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (LCD_writer_finished || wdog_lim) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sm_clk or negedge reset) begin
        if (!reset) begin
            owner       <= '0;
            last        <= IDX_W'(NUM_REQ - 1);
            db_q        <= 8'h00;
            cmd_q       <= 1'b0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner <= winner;
                        db_q  <= req_db_arr[winner];
                        cmd_q <= req_is_command[winner];
                    end
                end
                START: wdog <= '0;
                WAIT: begin
                    // A finish arriving on the limit cycle is a normal completion.
                    if (!LCD_writer_finished) begin
                        if (wdog_lim) begin
                            timeout_err <= 1'b1;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                end
                DONE:    last <= owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        grant = '0;
        done  = '0;
        if (state != IDLE) grant[owner] = 1'b1;
        if (state == DONE) done[owner]  = 1'b1;
    end

    assign busy             = (state != IDLE);
    assign start_LCD_writer = (state == START);
    assign DB               = busy ? db_q : 8'h00;
    assign is_command       = busy & cmd_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter: a driver plays requesters and the LCD writer,
// a transaction-level rotation model fills a scoreboard, and a monitor checks every cycle.
module tb_lcd_write_arbiter;
    localparam int NR = 3;
    localparam int TO = 8;

    logic            sm_clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_DB;
    logic [NR-1:0]   req_is_command;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;
    logic            timeout_err;
    logic            start_LCD_writer;
    logic            lcd_fin;
    logic [7:0]      DB;
    logic            is_command;

    lcd_write_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
        .sm_clk              (sm_clk),
        .reset               (reset),
        .req                 (req),
        .req_DB              (req_DB),
        .req_is_command      (req_is_command),
        .grant               (grant),
        .done                (done),
        .busy                (busy),
        .timeout_err         (timeout_err),
        .start_LCD_writer    (start_LCD_writer),
        .LCD_writer_finished (lcd_fin),
        .DB                  (DB),
        .is_command          (is_command)
    );

    always #5 sm_clk = ~sm_clk;

    int cyc = 0;
    always @(posedge sm_clk) cyc <= cyc + 1;

    typedef struct {
        int         owner;
        logic [7:0] db;
        logic       cmd;
    } exp_t;

    typedef struct {
        int cyc;
        bit to;
    } lat_t;

    exp_t exp_q [$];
    lat_t lat_q [$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] pack(logic [NR-1:0] g, logic [7:0] db, logic c, logic b,
                                         logic [NR-1:0] d, logic s, logic t);
        return 32'({g, db, c, b, d, s, t});
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial begin
        exp_t        cur;
        lat_t        lat;
        bit          active;
        bit          exp_terr;
        logic [31:0] obs;
        logic [NR-1:0] g_exp;
        active   = 1'b0;
        exp_terr = 1'b0;
        cur      = '{0, 8'h00, 1'b0};
        forever begin
            @(negedge sm_clk);
            obs   = pack(grant, DB, is_command, busy, done, start_LCD_writer, timeout_err);
            g_exp = NR'(1) << cur.owner;
            if (!reset) begin
                chk("reset_outputs", obs, pack('0, 8'h00, 1'b0, 1'b0, '0, 1'b0, 1'b0));
                active   = 1'b0;
                exp_terr = 1'b0;
                exp_q.delete();
                lat_q.delete();
            end else if (start_LCD_writer) begin
                chk("start_not_repeated", 32'(active), 32'(0));
                chk("start_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    cur    = exp_q[0];
                    g_exp  = NR'(1) << cur.owner;
                    active = 1'b1;
                    chk("start_outputs", obs, pack(g_exp, cur.db, cur.cmd, 1'b1, '0, 1'b1, exp_terr));
                end
            end else if (active && done != '0) begin
                chk("done_latency_entry", 32'(lat_q.size() != 0), 32'(1));
                if (lat_q.size() != 0) begin
                    lat      = lat_q.pop_front();
                    exp_terr = exp_terr | lat.to;
                    chk("done_cycle", 32'(cyc), 32'(lat.cyc));
                end
                void'(exp_q.pop_front());
                chk("done_outputs", obs, pack(g_exp, cur.db, cur.cmd, 1'b1, g_exp, 1'b0, exp_terr));
                active = 1'b0;
            end else if (active) begin
                chk("wait_outputs", obs, pack(g_exp, cur.db, cur.cmd, 1'b1, '0, 1'b0, exp_terr));
            end else begin
                chk("idle_outputs", obs, pack('0, 8'h00, 1'b0, 1'b0, '0, 1'b0, exp_terr));
            end
        end
    end

    // ---------------- driver and reference model ----------------
    int         model_last;
    int         plan_reps [NR];
    logic [7:0] plan_b0   [NR];
    logic       plan_c0   [NR];

    // fixed_d: WAIT cycles before finished (<0 random, >=TO never); abort_wait: cycles after start to pulse reset.
    task automatic run_round(input int fixed_d, input bit stale, input int abort_wait);
        logic [7:0] bq [NR][4];
        logic       cq [NR][4];
        int left [NR];
        int served [NR];
        int total, seen, budget, fin_cyc, d, o, abort_cnt, k;
        bit stale_on, started;
        exp_t e;
        lat_t l;

        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < 4; j++) begin
                bq[i][j] = (j == 0) ? plan_b0[i] : 8'($urandom);
                cq[i][j] = (j == 0) ? plan_c0[i] : 1'($urandom);
            end
        end

        // Rotation rule: each grant goes to the first still-pending requester after the last one served.
        total = 0;
        for (int i = 0; i < NR; i++) begin
            left[i]   = plan_reps[i];
            served[i] = 0;
            total    += plan_reps[i];
        end
        for (int n = 0; n < total; n++) begin
            o = model_last;
            k = 1;
            while (k <= NR) begin
                o = (model_last + k) % NR;
                if (left[o] > 0) break;
                k++;
            end
            e.owner = o;
            e.db    = bq[o][plan_reps[o] - left[o]];
            e.cmd   = cq[o][plan_reps[o] - left[o]];
            exp_q.push_back(e);
            left[o]--;
            model_last = o;
        end

        @(negedge sm_clk);
        for (int i = 0; i < NR; i++) begin
            req[i]            = (plan_reps[i] > 0);
            req_DB[8*i +: 8]  = bq[i][0];
            req_is_command[i] = cq[i][0];
        end
        stale_on  = stale;
        lcd_fin   = stale;
        fin_cyc   = -1;
        seen      = 0;
        budget    = 0;
        started   = 1'b0;
        abort_cnt = 0;

        while (seen < total) begin
            @(negedge sm_clk);
            budget++;
            if (budget > 40 * total + 20) begin
                $display("FAIL round_progress: got %0d of %0d done pulses, expected all within budget", seen, total);
                $fatal(1, "round did not complete");
            end
            if (start_LCD_writer) begin
                o = 0;
                for (int i = 0; i < NR; i++) if (grant[i]) o = i;
                d       = (fixed_d >= 0) ? fixed_d : $urandom_range(0, 10);
                fin_cyc = (d <= TO - 1) ? cyc + 1 + d : -1;
                l.cyc   = cyc + 2 + ((d <= TO - 1) ? d : TO - 1);
                l.to    = (d > TO - 1);
                lat_q.push_back(l);
                // Latched values must not follow the requester's bus after the grant.
                req_DB[8*o +: 8]  = 8'($urandom);
                req_is_command[o] = 1'($urandom);
                if (served[o] == plan_reps[o] - 1 && $urandom_range(0, 1) == 1) req[o] = 1'b0;
                if (abort_wait >= 0) started = 1'b1;
            end
            if (stale_on) begin
                lcd_fin = 1'b1;
                if (start_LCD_writer) stale_on = 1'b0;
            end else begin
                lcd_fin = (cyc == fin_cyc);
            end
            if (done != '0) begin
                for (int i = 0; i < NR; i++) begin
                    if (done[i] && served[i] < plan_reps[i]) begin
                        served[i]++;
                        if (served[i] < plan_reps[i]) begin
                            req[i]            = 1'b1;
                            req_DB[8*i +: 8]  = bq[i][served[i]];
                            req_is_command[i] = cq[i][served[i]];
                        end else begin
                            req[i] = 1'b0;
                        end
                    end
                end
                seen++;
            end
            if (started) begin
                abort_cnt++;
                if (abort_cnt == abort_wait) begin
                    @(posedge sm_clk);
                    #2;
                    reset   = 1'b0;
                    req     = '0;
                    lcd_fin = 1'b0;
                    @(posedge sm_clk);
                    #2;
                    reset      = 1'b1;
                    model_last = NR - 1;
                    return;
                end
            end
        end
        lcd_fin = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        req            = '1;
        req_DB         = 24'h123456;
        req_is_command = '1;
        lcd_fin        = 1'b0;
        model_last     = NR - 1;
        repeat (3) @(posedge sm_clk);
        @(negedge sm_clk);
        req = '0;
        @(posedge sm_clk);
        #2;
        reset = 1'b1;

        // contention from reset: service order 0,1,2
        plan_reps = '{1, 1, 1};
        plan_b0   = '{8'h01, 8'h80, 8'h5A};
        plan_c0   = '{1'b0, 1'b1, 1'b0};
        run_round(-1, 1'b0, -1);

        // rotation: 0 and 2 re-request, 1 idle
        plan_reps = '{2, 0, 2};
        plan_b0   = '{8'hC3, 8'h00, 8'h3C};
        plan_c0   = '{1'b1, 1'b0, 1'b0};
        run_round(-1, 1'b0, -1);

        // single request, finished 5 cycles after start, stale finished ignored before WAIT
        plan_reps = '{0, 1, 0};
        plan_b0   = '{8'h00, 8'h41, 8'h00};
        plan_c0   = '{1'b0, 1'b0, 1'b0};
        run_round(4, 1'b1, -1);

        // finished lands on the watchdog limit cycle
        plan_reps = '{0, 0, 1};
        plan_b0   = '{8'h00, 8'h00, 8'h77};
        run_round(TO - 1, 1'b0, -1);

        // writer never finishes, then a normal write with the sticky flag still set
        plan_reps = '{1, 0, 0};
        plan_b0   = '{8'hEE, 8'h00, 8'h00};
        run_round(100, 1'b0, -1);
        plan_reps = '{0, 1, 0};
        plan_b0   = '{8'h00, 8'h99, 8'h00};
        run_round(2, 1'b0, -1);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NR; i++) begin
                plan_reps[i] = $urandom_range(0, 2);
                plan_b0[i]   = 8'($urandom);
                plan_c0[i]   = 1'($urandom);
            end
            if (plan_reps[0] + plan_reps[1] + plan_reps[2] == 0) plan_reps[$urandom_range(0, NR - 1)] = 1;
            run_round(-1, ($urandom_range(0, 3) == 0), -1);
            repeat ($urandom_range(0, 2)) @(negedge sm_clk);
        end

        // reset in the middle of WAIT, then priority restarts at requester 0
        plan_reps = '{1, 1, 1};
        plan_b0   = '{8'h11, 8'h22, 8'h33};
        plan_c0   = '{1'b0, 1'b1, 1'b1};
        run_round(100, 1'b0, 3);
        repeat (3) @(negedge sm_clk);
        plan_b0 = '{8'hA1, 8'hB2, 8'hC3};
        run_round(-1, 1'b0, -1);

        repeat (3) @(negedge sm_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
